seg7_scan: RTL and testbench

//  Downstream display stage for the 4-digit BCD countdown timer. Registers the

---
 rtl/seg7_scan.sv | 140 ++++++++++++++
 tb/tb_seg7_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: latches four BCD digits once per scan frame and multiplexes them onto a
// 4-digit common-anode 7-segment display, with whole-display blink. Macro SEG_LZB_EN: leading-zero blanking.
module seg7_scan #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLINK_FRAMES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_mask,
    input  logic       blink,
    output logic [3:0] an_n,
    output logic [7:0] seg_n,
    output logic       frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    sel_q, sel_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic [3:0]    dig_sh_q [4];
    logic [3:0]    dig_sh_d [4];
    logic [3:0]    dp_sh_q, dp_sh_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;
    logic          slot_tick;
    logic          frame_tick;
`ifdef SEG_LZB_EN
    logic [3:0]    blank;
`endif

    // Active-low segment pattern, bit order g..a; non-BCD values show a dash.
    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        slot_tick  = (pre_q == PRE_MAX);
        frame_tick = slot_tick && (sel_q == 2'd3);
        pre_d      = slot_tick ? '0 : pre_q + 1'b1;
        sel_d      = slot_tick ? sel_q + 2'd1 : sel_q;
        fd_d       = frame_tick;

        // Shadow copy only moves at a frame boundary so a frame never mixes old and new digits.
        dig_sh_d = dig_sh_q;
        dp_sh_d  = dp_sh_q;
        if (frame_tick) begin
            dig_sh_d[3] = d3;
            dig_sh_d[2] = d2;
            dig_sh_d[1] = d1;
            dig_sh_d[0] = d0;
            dp_sh_d     = dp_mask;
        end

        frm_d   = frm_q;
        phase_d = phase_q;
        if (!blink) begin
            frm_d   = '0;
            phase_d = 1'b0;
        end else if (frame_tick) begin
            if (frm_q == FRM_MAX) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end

`ifdef SEG_LZB_EN
        blank[3] = (dig_sh_q[3] == 4'd0);
        blank[2] = blank[3] && (dig_sh_q[2] == 4'd0);
        blank[1] = blank[2] && (dig_sh_q[1] == 4'd0);
        blank[0] = 1'b0;
`endif

        an_d  = ~(4'b0001 << sel_q);
        seg_d = {~dp_sh_q[sel_q], dec7(dig_sh_q[sel_q])};
`ifdef SEG_LZB_EN
        if (blank[sel_q]) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end
`endif
        if (blink && phase_q) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            sel_q       <= 2'd0;
            frm_q       <= '0;
            phase_q     <= 1'b0;
            dig_sh_q[3] <= d3;
            dig_sh_q[2] <= d2;
            dig_sh_q[1] <= d1;
            dig_sh_q[0] <= d0;
            dp_sh_q     <= dp_mask;
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
            fd_q        <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            sel_q    <= sel_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            dig_sh_q <= dig_sh_d;
            dp_sh_q  <= dp_sh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and randomized stimulus for seg7_scan, checked every cycle
// against a timing model built from elapsed-cycle arithmetic. Honours SEG_LZB_EN.
module tb_seg7_scan;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic       clk;
    logic       rst;
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] dp_mask;
    logic       blink;
    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic       frame_done;

    int checks;
    int errors;

    // Reference state: edges since reset release, digits of the frame on display,
    // and frame boundaries seen while blink has been held high.
    int         k;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    int         bcnt;
    logic [6:0] seg_tab [16];

    seg7_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .dp_mask(dp_mask), .blink(blink),
        .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit dark_now();
        return blink && (((bcnt / BF) % 2) == 1);
    endfunction

    function automatic int lead_zeros();
        int n;
        n = 0;
        if (m_dig[3] == 4'd0) begin
            n = 1;
            if (m_dig[2] == 4'd0) begin
                n = 2;
                if (m_dig[1] == 4'd0) n = 3;
            end
        end
        return n;
    endfunction

    task automatic step();
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_fd;
        logic [3:0] in_dig [4];
        logic [3:0] in_dp;
        logic       in_blink;
        logic       in_rst;
        int         slot;
        int         kn;
        bit         hide;
        in_dig[3] = d3; in_dig[2] = d2; in_dig[1] = d1; in_dig[0] = d0;
        in_dp = dp_mask; in_blink = blink; in_rst = rst;
        kn = k + 1;
        if (in_rst) begin
            e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
        end else begin
            slot = (k / SD) % 4;
            e_fd = ((kn % FRAME) == 0);
            hide = dark_now();
`ifdef SEG_LZB_EN
            if (slot >= 4 - lead_zeros()) hide = 1'b1;
`endif
            if (hide) begin
                e_an = 4'hF; e_seg = 8'hFF;
            end else begin
                e_an = 4'hF;
                e_an[slot] = 1'b0;
                e_seg = {~m_dp[slot], seg_tab[m_dig[slot]]};
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert (an_n === e_an) else begin
            errors++;
            $error("FAIL an_n k=%0d got %b exp %b", kn, an_n, e_an);
        end
        checks++;
        assert (seg_n === e_seg) else begin
            errors++;
            $error("FAIL seg_n k=%0d got %h exp %h", kn, seg_n, e_seg);
        end
        checks++;
        assert (frame_done === e_fd) else begin
            errors++;
            $error("FAIL frame_done k=%0d got %b exp %b", kn, frame_done, e_fd);
        end
        if (in_rst) begin
            k = 0; m_dig = in_dig; m_dp = in_dp; bcnt = 0;
        end else begin
            k = kn;
            if (e_fd) begin
                m_dig = in_dig; m_dp = in_dp;
            end
            if (!in_blink) bcnt = 0;
            else if (e_fd) bcnt++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        checks = 0; errors = 0;
        k = 0; bcnt = 0; m_dp = 4'h0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

        // Reset with 4,3,2,1 on the inputs, then scan two frames.
        rst = 1'b1; blink = 1'b0; dp_mask = 4'h0;
        d3 = 4'd4; d2 = 4'd3; d1 = 4'd2; d0 = 4'd1;
        run(2);
        rst = 1'b0;
        run(32);

        // Mid-frame digit change stays hidden until the next boundary.
        guard = 0;
        while ((k % FRAME) != 9 && guard < 40) begin step(); guard++; end
        d0 = 4'd5;
        run(32);

        // Non-BCD value with a decimal point.
        d1 = 4'hA; dp_mask = 4'b0010;
        run(32);

        // Blink over several frames, then release it in a dark half.
        blink = 1'b1;
        run(80);
        guard = 0;
        while (!dark_now() && guard < 100) begin step(); guard++; end
        checks++;
        assert (dark_now()) else begin
            errors++;
            $error("FAIL blink_dark_reached got 0 exp 1");
        end
        run(5);
        blink = 1'b0;
        run(20);

        // Leading zeros.
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7; dp_mask = 4'h0;
        run(48);

        // Single-cycle reset in the middle of a slot.
        guard = 0;
        while ((k % SD) != 2 && guard < 10) begin step(); guard++; end
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(20);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            d3 = 4'($urandom_range(0, 15));
            d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 9));
            dp_mask = 4'($urandom_range(0, 15));
            blink = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 9) == 0);
            run(1);
            rst = 1'b0;
            run(int'($urandom_range(1, 40)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
